// File: rtl/cpu_b_pkg.sv
// Shared definitions for the register-transfer control path:
// opcodes, instruction field positions and the stepper length.
package cpu_b_pkg;

  typedef enum logic [1:0] {
    OP_MOV  = 2'b00,
    OP_CLR  = 2'b01,
    OP_SWAP = 2'b10,
    OP_NOP  = 2'b11
  } opcode_e;

  localparam int OPC_HI = 7;
  localparam int OPC_LO = 6;
  localparam int RS_HI  = 3;
  localparam int RS_LO  = 2;
  localparam int RD_HI  = 1;
  localparam int RD_LO  = 0;

  localparam logic [2:0] STEP_LAST = 3'd7;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/reg_xfer_ctrl_stepper.sv
// Instruction stepper: idles at 0, runs 1..NUM_STEPS once per start,
// then returns to 0. `last` marks the final step.
module stepper #(
  parameter int NUM_STEPS = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [2:0] step,
  output logic       last
);

  localparam logic [2:0] LAST = 3'(NUM_STEPS);

  logic [2:0] step_q;
  logic [2:0] step_d;

  always_ff @(posedge clk) begin
    if (reset) step_q <= '0;
    else       step_q <= step_d;
  end

  // start is only honoured from idle; an active sequence always runs to LAST
  always_comb begin
    step_d = step_q;
    if (step_q == 3'd0) begin
      if (start) step_d = 3'd1;
    end else if (step_q == LAST) begin
      step_d = 3'd0;
    end else begin
      step_d = step_q + 3'd1;
    end
  end

  assign step = step_q;
  assign last = (step_q == LAST);

endmodule

// File: rtl/reg_xfer_ctrl.sv
// Register-transfer sequencer for the four-entry GPR file: latches one
// instruction per handshake and drives the bus select lines step by step.
module reg_xfer_ctrl
  import cpu_b_pkg::*;
#(
  parameter int NUM_STEPS = int'(STEP_LAST)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] instr,
  input  logic       instr_valid,
  output logic       ready,
  output logic       s_r0,
  output logic       s_r1,
  output logic       s_r2,
  output logic       s_r3,
  output logic       e_r0,
  output logic       e_r1,
  output logic       e_r2,
  output logic       e_r3,
  output logic       s_tmp,
  output logic       e_tmp,
  output logic       bus_zero,
  output logic [2:0] step,
  output logic       done
);

  logic [7:0] ir;
  logic       accept;
  logic       last;
  opcode_e    opc;
  logic [1:0] rs;
  logic [1:0] rd;
  logic [3:0] set_r;
  logic [3:0] en_r;

  assign ready  = (step == 3'd0);
  assign accept = instr_valid && ready;

  always_ff @(posedge clk) begin
    if (reset)       ir <= 8'h00;
    else if (accept) ir <= instr;
  end

  stepper #(.NUM_STEPS(NUM_STEPS)) u_stepper (
    .clk   (clk),
    .reset (reset),
    .start (accept),
    .step  (step),
    .last  (last)
  );

  assign opc = opcode_e'(ir[OPC_HI:OPC_LO]);
  assign rs  = ir[RS_HI:RS_LO];
  assign rd  = ir[RD_HI:RD_LO];

  // Each transfer enables its source one step early so the bus has settled
  // for a full cycle before the matching set strobe latches it.
  always_comb begin
    set_r    = '0;
    en_r     = '0;
    s_tmp    = 1'b0;
    e_tmp    = 1'b0;
    bus_zero = 1'b0;
    case (opc)
      OP_MOV: begin
        if (step == 3'd1 || step == 3'd2) en_r  = onehot4(rs);
        if (step == 3'd2)                 set_r = onehot4(rd);
      end
      OP_CLR: begin
        if (step == 3'd1 || step == 3'd2) bus_zero = 1'b1;
        if (step == 3'd2)                 set_r    = onehot4(rd);
      end
      OP_SWAP: begin
        case (step)
          3'd1: en_r = onehot4(rs);
          3'd2: begin
            en_r  = onehot4(rs);
            s_tmp = 1'b1;
          end
          3'd3: en_r = onehot4(rd);
          3'd4: begin
            en_r  = onehot4(rd);
            set_r = onehot4(rs);
          end
          3'd5: e_tmp = 1'b1;
          3'd6: begin
            e_tmp = 1'b1;
            set_r = onehot4(rd);
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign {s_r3, s_r2, s_r1, s_r0} = set_r;
  assign {e_r3, e_r2, e_r1, e_r0} = en_r;
  assign done = last;

endmodule

// File: tb/tb_reg_xfer_ctrl.sv
// Bench for reg_xfer_ctrl: emulates the GPR file and bus around the DUT and
// compares register contents and handshake timing against an opcode-level model.
module tb_reg_xfer_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] instr;
  logic       instr_valid;
  logic       ready;
  logic       s_r0, s_r1, s_r2, s_r3;
  logic       e_r0, e_r1, e_r2, e_r3;
  logic       s_tmp, e_tmp, bus_zero;
  logic [2:0] step;
  logic       done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0]  gpr[4];
  logic [7:0]  tmp;
  logic [7:0]  ref_gpr[4];
  logic [10:0] trace[8];

  always #5 clk = ~clk;

  reg_xfer_ctrl #(.NUM_STEPS(7)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr       (instr),
    .instr_valid (instr_valid),
    .ready       (ready),
    .s_r0        (s_r0),
    .s_r1        (s_r1),
    .s_r2        (s_r2),
    .s_r3        (s_r3),
    .e_r0        (e_r0),
    .e_r1        (e_r1),
    .e_r2        (e_r2),
    .e_r3        (e_r3),
    .s_tmp       (s_tmp),
    .e_tmp       (e_tmp),
    .bus_zero    (bus_zero),
    .step        (step),
    .done        (done)
  );

  function automatic logic [15:0] obs_vec();
    return {ready, done, step, bus_zero, e_tmp, s_tmp,
            e_r3, e_r2, e_r1, e_r0, s_r3, s_r2, s_r1, s_r0};
  endfunction

  // One cycle: sample the strobes mid-cycle, check the bus rules, and let the
  // emulated register file latch whatever the strobes select at the coming edge.
  task automatic tick();
    logic [3:0] er;
    logic [3:0] sr;
    logic [7:0] bus;
    int nsrc;
    int nset;
    @(negedge clk);
    cyc++;
    er   = {e_r3, e_r2, e_r1, e_r0};
    sr   = {s_r3, s_r2, s_r1, s_r0};
    nsrc = $countones(er) + int'(e_tmp) + int'(bus_zero);
    nset = $countones(sr) + int'(s_tmp);
    checks++;
    if (nsrc > 1 || nset > 1 || (nset > 0 && nsrc == 0)) begin
      errors++;
      $display("[TB] FAIL bus_invariant cycle %0d: sources=%0d sets=%0d, required sources<=1, sets<=1, set only with a source",
               cyc, nsrc, nset);
    end
    bus = 8'hEE;
    if (bus_zero) bus = 8'h00;
    else if (e_tmp) bus = tmp;
    else for (int i = 0; i < 4; i++) if (er[i]) bus = gpr[i];
    for (int i = 0; i < 4; i++) if (sr[i]) gpr[i] = bus;
    if (s_tmp) tmp = bus;
    trace[step] = {bus_zero, e_tmp, s_tmp, er, sr};
  endtask

  task automatic model_apply(input logic [7:0] ins);
    logic [1:0] rs;
    logic [1:0] rd;
    logic [7:0] t;
    rs = ins[3:2];
    rd = ins[1:0];
    case (ins[7:6])
      2'b00: ref_gpr[rd] = ref_gpr[rs];
      2'b01: ref_gpr[rd] = 8'h00;
      2'b10: begin
        t           = ref_gpr[rs];
        ref_gpr[rs] = ref_gpr[rd];
        ref_gpr[rd] = t;
      end
      default: ;
    endcase
  endtask

  task automatic preload(input int idx, input logic [7:0] val);
    gpr[idx]     = val;
    ref_gpr[idx] = val;
  endtask

  // Issues one instruction and records when done/ready appear relative to the
  // acceptance edge; the caller decides what to compare.
  task automatic exec(input logic [7:0] ins, input bit scramble,
                      output int done_at, output int done_cnt,
                      output int ready_at, output bit seq_ok);
    int waitc;
    waitc    = 0;
    done_at  = -1;
    done_cnt = 0;
    ready_at = -1;
    seq_ok   = 1'b1;
    for (int i = 0; i < 8; i++) trace[i] = '0;
    while (ready !== 1'b1 && waitc < 20) begin
      tick();
      waitc++;
    end
    instr       = ins;
    instr_valid = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      tick();
      instr_valid = 1'b0;
      if (scramble) instr = 8'($urandom);
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
      if (ready === 1'b1 && ready_at < 0) ready_at = n;
      if (n <= 7 && step !== 3'(n)) seq_ok = 1'b0;
      if (n >= 8 && step !== 3'd0) seq_ok = 1'b0;
    end
    model_apply(ins);
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    instr_valid = 1'b0;
    instr       = 8'h00;
    tick();
    tick();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (obs_vec() !== 16'h8000) begin
        errors++;
        $display("[TB] FAIL reset_idle cycle %0d: outputs=%h required=%h", c, obs_vec(), 16'h8000);
      end
    end
  endtask

  task automatic test_mov();
    int da, dc, ra;
    bit ok;
    preload(1, 8'h55);
    preload(2, 8'h00);
    exec(8'h06, 1'b1, da, dc, ra, ok);
    checks++;
    if (da !== 7 || dc !== 1) begin
      errors++;
      $display("[TB] FAIL mov_done: done at %0d count %0d, required at 7 count 1", da, dc);
    end
    checks++;
    if (ra !== 8 || !ok) begin
      errors++;
      $display("[TB] FAIL mov_timing: ready at %0d seq_ok %0d, required 8 and 1", ra, ok);
    end
    checks++;
    if (trace[2] !== 11'b000_0010_0100) begin
      errors++;
      $display("[TB] FAIL mov_step2: strobes=%b required=%b", trace[2], 11'b000_0010_0100);
    end
    checks++;
    if (gpr[2] !== 8'h55) begin
      errors++;
      $display("[TB] FAIL mov_result: R2=%h required=55", gpr[2]);
    end
  endtask

  task automatic test_swap();
    int da, dc, ra;
    bit ok;
    preload(0, 8'h11);
    preload(3, 8'hFF);
    exec(8'h83, 1'b0, da, dc, ra, ok);
    checks++;
    if (da !== 7 || dc !== 1 || ra !== 8 || !ok) begin
      errors++;
      $display("[TB] FAIL swap_timing: done %0d/%0d ready %0d seq %0d, required 7/1 8 1", da, dc, ra, ok);
    end
    checks++;
    if (gpr[0] !== 8'hFF || gpr[3] !== 8'h11) begin
      errors++;
      $display("[TB] FAIL swap_result: R0=%h R3=%h required FF 11", gpr[0], gpr[3]);
    end
  endtask

  task automatic test_clr();
    int da, dc, ra;
    bit ok;
    logic [3:0] any_er;
    preload(2, 8'hAA);
    exec(8'h42, 1'b1, da, dc, ra, ok);
    any_er = '0;
    for (int i = 1; i < 8; i++) any_er |= trace[i][7:4];
    checks++;
    if (gpr[2] !== 8'h00) begin
      errors++;
      $display("[TB] FAIL clr_result: R2=%h required 00", gpr[2]);
    end
    checks++;
    if (any_er !== 4'b0000 || trace[2] !== 11'b100_0000_0100) begin
      errors++;
      $display("[TB] FAIL clr_strobes: e_r seen=%b step2=%b required 0000 and %b",
               any_er, trace[2], 11'b100_0000_0100);
    end
  endtask

  task automatic test_nop();
    int da, dc, ra;
    bit ok;
    logic [10:0] all_tr;
    exec({2'b11, 6'($urandom)}, 1'b1, da, dc, ra, ok);
    all_tr = '0;
    for (int i = 0; i < 8; i++) all_tr |= trace[i];
    checks++;
    if (all_tr !== '0 || da !== 7 || ra !== 8) begin
      errors++;
      $display("[TB] FAIL nop: strobes=%b done %0d ready %0d, required none 7 8", all_tr, da, ra);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (gpr[i] !== ref_gpr[i]) begin
        errors++;
        $display("[TB] FAIL nop_regs R%0d=%h required %h", i, gpr[i], ref_gpr[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc[$];
    logic [7:0] plan[$];
    bit mov_next;
    logic [7:0] ins;
    int waitc;
    mov_next = 1'b1;
    waitc = 0;
    while (ready !== 1'b1 && waitc < 20) begin
      tick();
      waitc++;
    end
    for (int i = 0; i < 4; i++) preload(i, 8'($urandom));
    instr_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (ready === 1'b1) begin
        ins = mov_next ? {2'b00, 2'($urandom), 2'($urandom), 2'($urandom)}
                       : {2'b11, 6'($urandom)};
        mov_next = !mov_next;
        plan.push_back(ins);
        instr = ins;
      end else begin
        instr = 8'($urandom);
      end
      tick();
      if (step === 3'd1) acc.push_back(c);
    end
    instr_valid = 1'b0;
    tick();
    foreach (plan[i]) model_apply(plan[i]);
    checks++;
    if (acc.size() != 5) begin
      errors++;
      $display("[TB] FAIL b2b_count: acceptances=%0d required 5", acc.size());
    end
    for (int i = 1; i < acc.size(); i++) begin
      checks++;
      if (acc[i] - acc[i-1] != 8) begin
        errors++;
        $display("[TB] FAIL b2b_spacing %0d: gap=%0d required 8", i, acc[i] - acc[i-1]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (gpr[i] !== ref_gpr[i]) begin
        errors++;
        $display("[TB] FAIL b2b_regs R%0d=%h required %h", i, gpr[i], ref_gpr[i]);
      end
    end
  endtask

  task automatic test_reset_mid_swap();
    int da, dc, ra;
    bit ok;
    preload(0, 8'h11);
    preload(3, 8'hFF);
    tmp = 8'h3C;
    instr       = 8'h83;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (step !== 3'd3) begin
      errors++;
      $display("[TB] FAIL midswap_step: step=%0d required 3", step);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (obs_vec() !== 16'h8000) begin
      errors++;
      $display("[TB] FAIL midswap_reset: outputs=%h required=%h", obs_vec(), 16'h8000);
    end
    checks++;
    if (gpr[0] !== 8'h11 || gpr[3] !== 8'hFF || tmp !== 8'h11) begin
      errors++;
      $display("[TB] FAIL midswap_regs: R0=%h R3=%h tmp=%h required 11 FF 11", gpr[0], gpr[3], tmp);
    end
    exec(8'h0C, 1'b0, da, dc, ra, ok);
    checks++;
    if (gpr[0] !== 8'hFF || da !== 7 || !ok) begin
      errors++;
      $display("[TB] FAIL after_reset_mov: R0=%h done %0d seq %0d required FF 7 1", gpr[0], da, ok);
    end
  endtask

  task automatic test_reset_with_valid();
    instr       = 8'h86;
    instr_valid = 1'b1;
    reset       = 1'b1;
    tick();
    reset       = 1'b0;
    instr_valid = 1'b0;
    checks++;
    if (step !== 3'd0 || ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_wins: step=%0d ready=%b required 0 1", step, ready);
    end
    tick();
    checks++;
    if (step !== 3'd0) begin
      errors++;
      $display("[TB] FAIL reset_drop: step=%0d required 0", step);
    end
  endtask

  task automatic test_random();
    int da, dc, ra;
    bit ok;
    for (int t = 0; t < 24; t++) begin
      if (($urandom % 3) == 0) preload(int'($urandom % 4), 8'($urandom));
      exec(8'($urandom), 1'b1, da, dc, ra, ok);
      checks++;
      if (da !== 7 || dc !== 1 || ra !== 8 || !ok) begin
        errors++;
        $display("[TB] FAIL rand_timing %0d: done %0d/%0d ready %0d seq %0d required 7/1 8 1",
                 t, da, dc, ra, ok);
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (gpr[i] !== ref_gpr[i]) begin
          errors++;
          $display("[TB] FAIL rand_regs %0d R%0d=%h required %h", t, i, gpr[i], ref_gpr[i]);
        end
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    instr_valid = 1'b0;
    instr       = 8'h00;
    tmp         = 8'h00;
    for (int i = 0; i < 4; i++) preload(i, 8'h00);
    test_reset();
    test_mov();
    test_swap();
    test_clr();
    test_nop();
    test_back_to_back();
    test_reset_mid_swap();
    test_reset_with_valid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
